mem_noc_arbiter_2to1: RTL and testbench
=======================================

MEM_NOC_ARBITER_2TO1 -- requirements
Module: mem_noc_arbiter_2to1

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin between masters, 0 = fixed priority to master 0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m0_req_valid  input  1  master 0 request valid.
REQ-005 m0_req_ready  output  1  master 0 request accepted.
REQ-006 m0_req  input  $bits(mem_req_t)  master 0 request payload.
REQ-007 m0_resp_valid  output  1  response valid to master 0.
REQ-008 m0_resp_ready  input  1  master 0 can take response.
REQ-009 m0_resp  output  $bits(mem_resp_t)  response payload to master 0.
REQ-010 m1_req_valid, m1_req_ready, m1_req, m1_resp_valid, m1_resp_ready, m1_resp: same directions, widths and meanings as the m0_* ports, for master 1.
REQ-011 s_req_valid  output  1  request valid to shared slave.
REQ-012 s_req_ready  input  1  slave accepts request.
REQ-013 s_req  output  $bits(mem_req_t)  forwarded request payload.
REQ-014 s_resp_valid  input  1  slave response valid.
REQ-015 s_resp_ready  output  1  response ready to slave.
REQ-016 s_resp  input  $bits(mem_resp_t)  slave response payload.
REQ-017 grant_id  output  1  master owning the current transaction (= owner register).
REQ-018 busy  output  1  high whenever state != IDLE.

Function
REQ-019 States: IDLE, HOLD (request presented to slave, not yet accepted), RESP (request accepted, awaiting response); at most one outstanding transaction.
REQ-020 Registers: state, owner (1b), rr_ptr (1b); rr_ptr=0 favours m0, rr_ptr=1 favours m1.
REQ-021 arb_ok = (state==IDLE) | (state==RESP & s_resp_valid & s_resp_ready).
REQ-022 Winner when arb_ok: only one valid -> that master; both valid -> m{rr_ptr} if RR_EN=1, m0 if RR_EN=0.
REQ-023 When arb_ok: s_req_valid = m0_req_valid | m1_req_valid; s_req = winner's payload; winner's req_ready = s_req_ready; loser's req_ready = 0.
REQ-024 In HOLD: winner locked to owner; s_req_valid = owner's req_valid; s_req = owner's payload; owner's req_ready = s_req_ready; other master's req_ready = 0; a newly valid non-owner shall not change s_req.
REQ-025 In RESP without response handshake: s_req_valid = 0; both req_ready = 0.
REQ-026 owner loads winner id on any cycle where arb_ok & s_req_valid (accepted or not).
REQ-027 rr_ptr loads ~winner on every request handshake (s_req_valid & s_req_ready) when RR_EN=1; it holds otherwise.
REQ-028 IDLE -> RESP on request handshake; IDLE -> HOLD on s_req_valid & ~s_req_ready; otherwise stays IDLE.
REQ-029 HOLD -> RESP on s_req_ready & owner valid; HOLD -> IDLE if owner drops valid (protocol violation, tolerated); otherwise stays HOLD.
REQ-030 RESP with response handshake: new request handshake -> RESP; new valid but not ready -> HOLD; no valid -> IDLE. Without response handshake, stays RESP.
REQ-031 Response routing: in RESP, m{owner}_resp_valid = s_resp_valid, m{owner}_resp = s_resp, s_resp_ready = m{owner}_resp_ready; the other master's resp_valid = 0 and its resp = 0.
REQ-032 Outside RESP: s_resp_ready = 0, both resp_valid = 0; s_resp_valid is ignored.
REQ-033 The request and response paths are combinational (zero added latency); back-to-back transactions need no idle cycle.
REQ-034 Response routing in REQ-031 uses the owner value from before the edge, even when a new request is granted in the same cycle.

Reset
REQ-035 When rst=1 at a clock edge: state=IDLE, owner=0, rr_ptr=0.
REQ-036 After reset with all inputs 0: all valid/ready outputs are 0, grant_id=0, busy=0.
REQ-037 rst asserted in HOLD or RESP abandons the transaction, with no response forwarded afterwards.

Verification
REQ-038 Both masters valid, RR_EN=1, s_req_ready=1, instant responses -> grants alternate m0,m1,m0,m1 over 4 transactions.
REQ-039 RR_EN=0, both masters continuously valid -> m0 wins all 4 transactions; m1_req_ready stays 0.
REQ-040 m1 valid, rr_ptr=0, s_req_ready=0 for 3 cycles, m0 rises in cycle 2 -> state HOLD, s_req stays m1 payload, m1 accepted in cycle 4, m0_req_ready=0 throughout.
REQ-041 m0 request with req_addr=0x100 accepted; m0_resp_ready=0 for 2 cycles while s_resp_valid=1 -> s_resp_ready=0 for those cycles, m1_resp_valid=0, single handshake then IDLE.
REQ-042 Response handshake and new m1 request handshake in the same cycle -> state stays RESP, grant_id becomes 1, no idle cycle.
REQ-043 rst pulsed during RESP -> next cycle busy=0, grant_id=0, late s_resp_valid=1 gives m0_resp_valid=m1_resp_valid=0.

Source files
------------

// File: rtl/mem_noc_arbiter_2to1.sv
// Two-master to one-slave memory request arbiter with a single outstanding transaction.
// Requests and responses pass through combinationally; owner/rr_ptr track grant history.

package mem_noc_arbiter_2to1_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              req_we;
        logic [ADDR_W-1:0] req_addr;
        logic [DATA_W-1:0] req_wdata;
    } mem_req_t;

    typedef struct packed {
        logic              resp_err;
        logic [DATA_W-1:0] resp_rdata;
    } mem_resp_t;

endpackage

module mem_noc_arbiter_2to1
    import mem_noc_arbiter_2to1_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,

    input  logic      m0_req_valid,
    output logic      m0_req_ready,
    input  mem_req_t  m0_req,
    output logic      m0_resp_valid,
    input  logic      m0_resp_ready,
    output mem_resp_t m0_resp,

    input  logic      m1_req_valid,
    output logic      m1_req_ready,
    input  mem_req_t  m1_req,
    output logic      m1_resp_valid,
    input  logic      m1_resp_ready,
    output mem_resp_t m1_resp,

    output logic      s_req_valid,
    input  logic      s_req_ready,
    output mem_req_t  s_req,
    input  logic      s_resp_valid,
    output logic      s_resp_ready,
    input  mem_resp_t s_resp,

    output logic      grant_id,
    output logic      busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   rr_ptr_q, rr_ptr_d;

    logic   resp_hs;
    logic   arb_ok;
    logic   winner;
    logic   req_hs;

    // State, owner and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Routing, arbitration and next-state logic
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        m0_resp       = '0;
        m1_resp       = '0;
        s_resp_ready  = 1'b0;
        s_req_valid   = 1'b0;
        winner        = owner_q;

        // Response path always follows the owner registered before this edge
        if (state_q == ST_RESP) begin
            if (owner_q) begin
                m1_resp_valid = s_resp_valid;
                m1_resp       = s_resp;
                s_resp_ready  = m1_resp_ready;
            end else begin
                m0_resp_valid = s_resp_valid;
                m0_resp       = s_resp;
                s_resp_ready  = m0_resp_ready;
            end
        end

        resp_hs = (state_q == ST_RESP) && s_resp_valid && s_resp_ready;
        arb_ok  = (state_q == ST_IDLE) || resp_hs;

        if (arb_ok) begin
            if (m0_req_valid && m1_req_valid) begin
                winner = RR_EN ? rr_ptr_q : 1'b0;
            end else begin
                winner = m1_req_valid;
            end
            s_req_valid = m0_req_valid || m1_req_valid;
        end else if (state_q == ST_HOLD) begin
            s_req_valid = owner_q ? m1_req_valid : m0_req_valid;
        end

        s_req        = winner ? m1_req : m0_req;
        req_hs       = s_req_valid && s_req_ready;
        m0_req_ready = req_hs && !winner;
        m1_req_ready = req_hs && winner;

        if (arb_ok && s_req_valid) begin
            owner_d = winner;
        end
        if (RR_EN && req_hs) begin
            rr_ptr_d = ~winner;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    state_d = ST_RESP;
                end else if (s_req_valid) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Owner withdrawing its request is tolerated by falling back to IDLE
                if (req_hs) begin
                    state_d = ST_RESP;
                end else if (!s_req_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (resp_hs) begin
                    if (req_hs) begin
                        state_d = ST_RESP;
                    end else if (s_req_valid) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant_id = owner_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_noc_arbiter_2to1.sv
// Scoreboard bench for mem_noc_arbiter_2to1: round-robin instance plus a fixed-priority instance.

module tb_mem_noc_arbiter_2to1;
    import mem_noc_arbiter_2to1_pkg::*;

    logic clk;
    logic rst;

    logic      m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic      m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
    mem_req_t  m0_req, m1_req, s_req;
    mem_resp_t m0_resp, m1_resp, s_resp;
    logic      s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
    logic      grant_id, busy;

    logic      f_m0_req_valid, f_m0_req_ready, f_m0_resp_valid, f_m0_resp_ready;
    logic      f_m1_req_valid, f_m1_req_ready, f_m1_resp_valid, f_m1_resp_ready;
    mem_req_t  f_m0_req, f_m1_req, f_s_req;
    mem_resp_t f_m0_resp, f_m1_resp, f_s_resp;
    logic      f_s_req_valid, f_s_req_ready, f_s_resp_valid, f_s_resp_ready;
    logic      f_grant_id, f_busy;

    mem_noc_arbiter_2to1 #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req(s_req),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp(s_resp),
        .grant_id(grant_id), .busy(busy)
    );

    mem_noc_arbiter_2to1 #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req_valid(f_m0_req_valid), .m0_req_ready(f_m0_req_ready), .m0_req(f_m0_req),
        .m0_resp_valid(f_m0_resp_valid), .m0_resp_ready(f_m0_resp_ready), .m0_resp(f_m0_resp),
        .m1_req_valid(f_m1_req_valid), .m1_req_ready(f_m1_req_ready), .m1_req(f_m1_req),
        .m1_resp_valid(f_m1_resp_valid), .m1_resp_ready(f_m1_resp_ready), .m1_resp(f_m1_resp),
        .s_req_valid(f_s_req_valid), .s_req_ready(f_s_req_ready), .s_req(f_s_req),
        .s_resp_valid(f_s_resp_valid), .s_resp_ready(f_s_resp_ready), .s_resp(f_s_resp),
        .grant_id(f_grant_id), .busy(f_busy)
    );

    typedef struct packed {
        logic     id;
        mem_req_t req;
    } exp_req_t;

    typedef struct packed {
        logic      id;
        mem_resp_t resp;
    } exp_resp_t;

    exp_req_t  exp_req_q[$];
    exp_resp_t exp_resp_q[$];
    exp_req_t  mon_req;
    exp_resp_t mon_resp;

    int n_pass;
    int n_total;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    function automatic mem_req_t mk_req(input logic [31:0] a);
        mem_req_t r;
        r.req_we    = a[0];
        r.req_addr  = a;
        r.req_wdata = ~a;
        return r;
    endfunction

    function automatic mem_resp_t mk_resp(input logic [31:0] d);
        mem_resp_t r;
        r.resp_err   = d[1];
        r.resp_rdata = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input logic id, input logic [31:0] a);
        exp_req_t e;
        e.id  = id;
        e.req = mk_req(a);
        exp_req_q.push_back(e);
    endtask

    task automatic push_resp(input logic id, input logic [31:0] d);
        exp_resp_t e;
        e.id   = id;
        e.resp = mk_resp(d);
        exp_resp_q.push_back(e);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Monitor: every handshake the DUT presents is matched against the next expected item
    always @(negedge clk) begin
        if (!rst) begin
            if (s_req_valid && s_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_req: grant=%0d addr=%0h required=none", m1_req_ready, s_req.req_addr);
                end else begin
                    mon_req = exp_req_q.pop_front();
                    chk("req_grant", 128'({m1_req_ready, m0_req_ready}), 128'(mon_req.id ? 2'b10 : 2'b01));
                    chk("req_payload", 128'(s_req), 128'(mon_req.req));
                end
            end
            if (m0_resp_valid && m0_resp_ready) begin
                if (exp_resp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_resp_m0: data=%0h required=none", m0_resp.resp_rdata);
                end else begin
                    mon_resp = exp_resp_q.pop_front();
                    chk("resp_m0_id", 128'(1'b0), 128'(mon_resp.id));
                    chk("resp_m0_payload", 128'(m0_resp), 128'(mon_resp.resp));
                end
            end
            if (m1_resp_valid && m1_resp_ready) begin
                if (exp_resp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_resp_m1: data=%0h required=none", m1_resp.resp_rdata);
                end else begin
                    mon_resp = exp_resp_q.pop_front();
                    chk("resp_m1_id", 128'(1'b1), 128'(mon_resp.id));
                    chk("resp_m1_payload", 128'(m1_resp), 128'(mon_resp.resp));
                end
            end
        end
    end

    initial begin
        logic [3:0] rr_gid;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
        m0_req = '0; m1_req = '0; s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp = '0;
        f_m0_req_valid = 1'b0; f_m1_req_valid = 1'b0; f_m0_resp_ready = 1'b0; f_m1_resp_ready = 1'b0;
        f_m0_req = '0; f_m1_req = '0; f_s_req_ready = 1'b0; f_s_resp_valid = 1'b0; f_s_resp = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        at_neg();
        chk("rst_handshake_outs", 128'({s_req_valid, m0_req_ready, m1_req_ready,
                                        m0_resp_valid, m1_resp_valid, s_resp_ready}), 128'(6'b0));
        chk("rst_grant_id", 128'(grant_id), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_fp_busy", 128'({f_busy, f_grant_id, f_s_req_valid}), 128'(3'b0));

        // Fixed priority: m0 wins every transaction while both are valid
        adv();
        f_m0_req_valid = 1'b1; f_m1_req_valid = 1'b1;
        f_m0_req = mk_req(32'h0A0); f_m1_req = mk_req(32'h0B0);
        f_s_req_ready = 1'b1; f_s_resp_valid = 1'b1; f_s_resp = mk_resp(32'h1234);
        f_m0_resp_ready = 1'b1; f_m1_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("fp_m0_ready", 128'(f_m0_req_ready), 128'(1'b1));
            chk("fp_m1_ready", 128'(f_m1_req_ready), 128'(1'b0));
            chk("fp_s_req", 128'(f_s_req), 128'(mk_req(32'h0A0)));
            if (i > 0) begin
                chk("fp_resp_route", 128'({f_m0_resp_valid, f_m1_resp_valid}), 128'(2'b10));
                chk("fp_grant_id", 128'(f_grant_id), 128'(1'b0));
            end
            adv();
        end
        f_m0_req_valid = 1'b0; f_m1_req_valid = 1'b0;
        at_neg();
        chk("fp_last_resp", 128'({f_m0_resp_valid, f_m1_resp_valid, f_s_req_valid}), 128'(3'b100));
        adv();
        f_s_resp_valid = 1'b0;
        at_neg();
        chk("fp_idle", 128'(f_busy), 128'(1'b0));

        // Round-robin alternation with back-to-back instant responses
        adv();
        push_req(1'b0, 32'h10); push_req(1'b1, 32'h20); push_req(1'b0, 32'h10); push_req(1'b1, 32'h20);
        push_resp(1'b0, 32'hA1); push_resp(1'b1, 32'hA2); push_resp(1'b0, 32'hA3); push_resp(1'b1, 32'hA4);
        rr_gid = 4'b1010;
        m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        m0_req = mk_req(32'h10); m1_req = mk_req(32'h20);
        s_req_ready = 1'b1; s_resp_valid = 1'b1; m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_resp = mk_resp(32'(32'hA0 + k));
            if (k == 4) begin
                m0_req_valid = 1'b0;
                m1_req_valid = 1'b0;
            end
            at_neg();
            if (k == 0) begin
                chk("idle_ignores_resp", 128'({m0_resp_valid, m1_resp_valid, s_resp_ready}), 128'(3'b000));
            end else begin
                chk("rr_grant_id", 128'(grant_id), 128'(rr_gid[k-1]));
            end
            adv();
        end
        s_resp_valid = 1'b0;
        at_neg();
        chk("rr_back_idle", 128'(busy), 128'(1'b0));

        // HOLD: m1 presented while slave stalls, m0 arriving later must not steal it
        adv();
        push_req(1'b1, 32'h30); push_req(1'b0, 32'h40);
        push_resp(1'b1, 32'hB5); push_resp(1'b0, 32'hC6);
        m1_req_valid = 1'b1; m1_req = mk_req(32'h30); s_req_ready = 1'b0;
        at_neg();
        chk("hold_c1_s_req", 128'({s_req_valid, s_req}), 128'({1'b1, mk_req(32'h30)}));
        adv();
        m0_req_valid = 1'b1; m0_req = mk_req(32'h40);
        at_neg();
        chk("hold_c2_state", 128'({busy, grant_id}), 128'(2'b11));
        chk("hold_c2_s_req", 128'(s_req), 128'(mk_req(32'h30)));
        chk("hold_c2_readies", 128'({m0_req_ready, m1_req_ready}), 128'(2'b00));
        adv();
        at_neg();
        chk("hold_c3_s_req", 128'(s_req), 128'(mk_req(32'h30)));
        chk("hold_c3_m0_ready", 128'(m0_req_ready), 128'(1'b0));
        adv();
        s_req_ready = 1'b1;
        at_neg();
        chk("hold_c4_m0_ready", 128'(m0_req_ready), 128'(1'b0));
        adv();
        m1_req_valid = 1'b0; s_resp_valid = 1'b1; s_resp = mk_resp(32'hB5);
        at_neg();
        chk("old_owner_route", 128'({m1_resp_valid, m0_resp_valid, grant_id}), 128'(3'b101));
        adv();
        m0_req_valid = 1'b0; s_resp = mk_resp(32'hC6);
        at_neg();
        chk("c6_grant_id", 128'(grant_id), 128'(1'b0));
        adv();

        // Response backpressure from m0
        s_resp_valid = 1'b0;
        push_req(1'b0, 32'h100);
        m0_req_valid = 1'b1; m0_req = mk_req(32'h100);
        at_neg();
        adv();
        m0_req_valid = 1'b0; s_resp_valid = 1'b1; s_resp = mk_resp(32'hD0); m0_resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("bp_s_resp_ready", 128'(s_resp_ready), 128'(1'b0));
            chk("bp_resp_valids", 128'({m0_resp_valid, m1_resp_valid, busy}), 128'(3'b101));
            adv();
        end
        push_resp(1'b0, 32'hD0);
        m0_resp_ready = 1'b1;
        at_neg();
        adv();
        at_neg();
        chk("bp_after_idle", 128'({busy, m0_resp_valid, s_resp_ready}), 128'(3'b000));
        adv();

        // Response handshake and new grant in the same cycle, then reset during RESP
        s_resp_valid = 1'b0;
        push_req(1'b0, 32'h200);
        m0_req_valid = 1'b1; m0_req = mk_req(32'h200);
        at_neg();
        adv();
        push_resp(1'b0, 32'hE0); push_req(1'b1, 32'h201);
        m0_req_valid = 1'b0; m1_req_valid = 1'b1; m1_req = mk_req(32'h201);
        s_resp_valid = 1'b1; s_resp = mk_resp(32'hE0);
        at_neg();
        chk("b2b_pre_grant", 128'({grant_id, m1_req_ready}), 128'(2'b01));
        adv();
        m1_req_valid = 1'b0; s_resp_valid = 1'b0; rst = 1'b1;
        at_neg();
        chk("b2b_post_grant", 128'({busy, grant_id}), 128'(2'b11));
        adv();
        rst = 1'b0; s_resp_valid = 1'b1; s_resp = mk_resp(32'hEE);
        at_neg();
        chk("rst_abandon_state", 128'({busy, grant_id}), 128'(2'b00));
        chk("rst_abandon_resp", 128'({m0_resp_valid, m1_resp_valid, s_resp_ready}), 128'(3'b000));
        adv();

        // rr_ptr cleared by reset, then remembered across an idle gap
        s_resp_valid = 1'b0;
        push_req(1'b0, 32'h300);
        m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        m0_req = mk_req(32'h300); m1_req = mk_req(32'h310);
        at_neg();
        adv();
        push_resp(1'b0, 32'hF0);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_resp_valid = 1'b1; s_resp = mk_resp(32'hF0);
        at_neg();
        adv();
        push_req(1'b1, 32'h330);
        s_resp_valid = 1'b0;
        m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        m0_req = mk_req(32'h320); m1_req = mk_req(32'h330);
        at_neg();
        adv();
        push_resp(1'b1, 32'hF1);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_resp_valid = 1'b1; s_resp = mk_resp(32'hF1);
        at_neg();
        adv();

        // Owner dropping valid in HOLD returns to IDLE without forwarding anything
        s_resp_valid = 1'b0;
        m0_req_valid = 1'b1; m0_req = mk_req(32'h400); s_req_ready = 1'b0;
        at_neg();
        chk("drop_c1_ready", 128'(m0_req_ready), 128'(1'b0));
        adv();
        m0_req_valid = 1'b0; m1_req_valid = 1'b1; m1_req = mk_req(32'h410); s_req_ready = 1'b1;
        at_neg();
        chk("drop_c2_hold", 128'({s_req_valid, m1_req_ready, busy}), 128'(3'b001));
        adv();
        push_req(1'b1, 32'h410);
        at_neg();
        chk("drop_c3_idle", 128'(busy), 128'(1'b0));
        adv();
        push_resp(1'b1, 32'h55);
        m1_req_valid = 1'b0; s_resp_valid = 1'b1; s_resp = mk_resp(32'h55);
        at_neg();
        adv();
        s_resp_valid = 1'b0;
        at_neg();
        chk("final_idle", 128'(busy), 128'(1'b0));

        chk("req_queue_drained", 128'(exp_req_q.size()), 128'(0));
        chk("resp_queue_drained", 128'(exp_resp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
